// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UartTx byte serializer among NREQ requesters.
// Optional per-packet header byte (8'hA0|k) is enabled by defining UART_ARB_HDR_EN.
module uart_tx_arbiter #(
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic [NREQ-1:0]   i_req,
   input  logic [8*NREQ-1:0] i_data,
   input  logic [NREQ-1:0]   i_last,
   output logic [NREQ-1:0]   o_ack,
   output logic [NREQ-1:0]   o_grant,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_wen,
   input  logic              i_tx_ready,
   output logic              o_busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_GUARD = 3'd2,
`ifdef UART_ARB_HDR_EN
      S_WAIT  = 3'd3,
      S_HDR   = 3'd4
`else
      S_WAIT  = 3'd3
`endif
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   last, last_nxt;
   logic [IW-1:0]   gidx, gidx_nxt;
   logic            lastf, lastf_nxt;
   logic [NREQ-1:0] ack_nxt, grant_nxt;
   logic [7:0]      tx_data_nxt;
   logic            wen_nxt;
   logic [IW-1:0]   pick;
   logic            found;
   logic [7:0]      data_arr [NREQ];

   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         data_arr[k] = i_data[8*k +: 8];
      end
   end

   // Search starts one past the previous owner so every requester gets a turn.
   always_comb begin
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!found && i_req[IW'((int'(last) + i) % NREQ)]) begin
            found = 1'b1;
            pick  = IW'((int'(last) + i) % NREQ);
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      last_nxt    = last;
      gidx_nxt    = gidx;
      lastf_nxt   = lastf;
      grant_nxt   = o_grant;
      tx_data_nxt = o_tx_data;
      wen_nxt     = 1'b0;
      ack_nxt     = '0;
      case (state)
         S_IDLE: begin
            if (found) begin
               gidx_nxt  = pick;
               grant_nxt = NREQ'(1) << pick;
`ifdef UART_ARB_HDR_EN
               state_nxt = S_HDR;
`else
               state_nxt = S_LOAD;
`endif
            end
         end
`ifdef UART_ARB_HDR_EN
         S_HDR: begin
            // lastf cleared so the wait after the header always leads into the payload.
            if (i_tx_ready) begin
               tx_data_nxt = 8'hA0 | 8'(gidx);
               wen_nxt     = 1'b1;
               lastf_nxt   = 1'b0;
               state_nxt   = S_GUARD;
            end
         end
`endif
         S_LOAD: begin
            if (!i_req[gidx]) begin
               grant_nxt = '0;
               last_nxt  = gidx;
               state_nxt = S_IDLE;
            end else if (i_tx_ready) begin
               tx_data_nxt = data_arr[gidx];
               wen_nxt     = 1'b1;
               ack_nxt     = NREQ'(1) << gidx;
               lastf_nxt   = i_last[gidx];
               state_nxt   = S_GUARD;
            end
         end
         // UartTx still shows ready in the cycle right after the write strobe.
         S_GUARD: state_nxt = S_WAIT;
         S_WAIT: begin
            if (i_tx_ready) begin
               if (lastf) begin
                  grant_nxt = '0;
                  last_nxt  = gidx;
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_LOAD;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         last      <= IW'(NREQ - 1);
         gidx      <= '0;
         lastf     <= 1'b0;
         o_grant   <= '0;
         o_ack     <= '0;
         o_tx_data <= '0;
         o_tx_wen  <= 1'b0;
         o_busy    <= 1'b0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         gidx      <= gidx_nxt;
         lastf     <= lastf_nxt;
         o_grant   <= grant_nxt;
         o_ack     <= ack_nxt;
         o_tx_data <= tx_data_nxt;
         o_tx_wen  <= wen_nxt;
         o_busy    <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a UartTx ready model (ready returns 2000 cycles after wen).
// Header-byte scenario runs instead of the raw-payload scenarios when UART_ARB_HDR_EN is defined.
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              i_rst;
   logic [NREQ-1:0]   i_req;
   logic [8*NREQ-1:0] i_data;
   logic [NREQ-1:0]   i_last;
   logic [NREQ-1:0]   o_ack;
   logic [NREQ-1:0]   o_grant;
   logic [7:0]        o_tx_data;
   logic              o_tx_wen;
   logic              i_tx_ready;
   logic              o_busy;

   uart_tx_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_data(i_data), .i_last(i_last),
      .o_ack(o_ack), .o_grant(o_grant), .o_tx_data(o_tx_data), .o_tx_wen(o_tx_wen),
      .i_tx_ready(i_tx_ready), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   // UartTx model: ready drops the cycle after wen and returns 2000 cycles later.
   int   cnt = 0;
   logic hold_low;
   always @(posedge clk) begin
      if (i_rst) cnt <= 0;
      else if (o_tx_wen) cnt <= 2000;
      else if (cnt != 0) cnt <= cnt - 1;
   end
   assign i_tx_ready = (cnt == 0) && !hold_low;

   int total = 0;
   int bad = 0;
   logic [7:0]      pdat [NREQ][4];
   logic [3:0]      plm  [NREQ];
   int              plen [NREQ];
   int              ppos [NREQ];
   logic [7:0]      wq [$];
   logic [NREQ-1:0] aq [$];
   int              wen_by [NREQ];
   int              ack_cnt;
   int              multi_hot = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (ppos[k] < 4) ? ppos[k] : 3;
         i_req[k]        = (ppos[k] < plen[k]);
         i_data[8*k +: 8] = pdat[k][idx];
         i_last[k]       = plm[k][idx];
      end
   endtask

   task automatic clear_pkts();
      for (int k = 0; k < NREQ; k++) begin
         plen[k] = 0;
         ppos[k] = 0;
         plm[k]  = '0;
         wen_by[k] = 0;
         for (int i = 0; i < 4; i++) pdat[k][i] = 8'h00;
      end
      wq.delete();
      aq.delete();
      ack_cnt = 0;
   endtask

   // bytes packed {b3,b2,b1,b0}; lm bit i marks byte i as last of its packet
   task automatic arm(input int k, input int n, input logic [31:0] bytes, input logic [3:0] lm);
      plen[k] = n;
      ppos[k] = 0;
      plm[k]  = lm;
      for (int i = 0; i < 4; i++) pdat[k][i] = bytes[8*i +: 8];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!$onehot0(o_grant)) multi_hot++;
      if (o_tx_wen) begin
         wq.push_back(o_tx_data);
         aq.push_back(o_ack);
         for (int k = 0; k < NREQ; k++) if (o_grant[k]) wen_by[k]++;
      end
      if (|o_ack) ack_cnt++;
      for (int k = 0; k < NREQ; k++) if (o_ack[k]) ppos[k]++;
      drive();
   endtask

   function automatic bit any_on();
      for (int k = 0; k < NREQ; k++) if (ppos[k] < plen[k]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((o_busy || any_on()) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < budget), 32'd1);
   endtask

   initial begin
      i_rst = 1'b1;
      hold_low = 1'b0;
      i_req = '0;
      i_data = '0;
      i_last = '0;
      clear_pkts();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", 32'(o_grant), 32'h0);
      chk("rst_ack", 32'(o_ack), 32'h0);
      chk("rst_wen", 32'(o_tx_wen), 32'h0);
      chk("rst_data", 32'(o_tx_data), 32'h0);
      chk("rst_busy", 32'(o_busy), 32'h0);
      i_rst = 1'b0;

`ifdef UART_ARB_HDR_EN
      // Header scenario: req2 sends one byte 8'h3C, preceded by header 8'hA2
      arm(2, 1, 32'h0000003C, 4'b0001);
      drive();
      tick();
      chk("hdr_grant", 32'(o_grant), 32'h4);
      tick();
      chk("hdr_wen", 32'(o_tx_wen), 32'h1);
      chk("hdr_byte", 32'(o_tx_data), 32'hA2);
      chk("hdr_noack", 32'(o_ack), 32'h0);
      wait_idle("hdr_timeout", 10000);
      chk("hdr_count", 32'(wq.size()), 32'd2);
      chk("hdr_wire0", 32'(wq[0]), 32'hA2);
      chk("hdr_wire1", 32'(wq[1]), 32'h3C);
      chk("hdr_ack0", 32'(aq[0]), 32'h0);
      chk("hdr_ack1", 32'(aq[1]), 32'h4);
      chk("hdr_idle_grant", 32'(o_grant), 32'h0);
`else
      // Single 1-byte packet, latency check
      arm(0, 1, 32'h00000055, 4'b0001);
      drive();
      tick();
      chk("t1_grant_c1", 32'(o_grant), 32'h1);
      chk("t1_nowen_c1", 32'(o_tx_wen), 32'h0);
      chk("t1_busy_c1", 32'(o_busy), 32'h1);
      tick();
      chk("t1_wen_c2", 32'(o_tx_wen), 32'h1);
      chk("t1_ack_c2", 32'(o_ack), 32'h1);
      chk("t1_data_c2", 32'(o_tx_data), 32'h55);
      wait_idle("t1_timeout", 5000);
      chk("t1_grant_end", 32'(o_grant), 32'h0);
      chk("t1_busy_end", 32'(o_busy), 32'h0);
      chk("t1_count", 32'(wq.size()), 32'd1);

      // Two competing 3-byte packets; req1 re-requests and must yield to req2
      clear_pkts();
      arm(1, 4, 32'h14131211, 4'b1100);
      arm(2, 3, 32'h00232221, 4'b0100);
      drive();
      wait_idle("t2_timeout", 20000);
      chk("t2_count", 32'(wq.size()), 32'd7);
      begin
         logic [7:0] exp2 [7];
         exp2 = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h14};
         for (int i = 0; i < 7; i++) chk($sformatf("t2_byte%0d", i), 32'(wq[i]), 32'(exp2[i]));
      end

      // Abort: req0 drops after a non-last byte, waiting req3 gets served
      clear_pkts();
      arm(0, 1, 32'h00000001, 4'b0000);
      drive();
      tick();
      chk("t3_grant0", 32'(o_grant), 32'h1);
      arm(3, 1, 32'h00000033, 4'b0001);
      drive();
      wait_idle("t3_timeout", 10000);
      chk("t3_count", 32'(wq.size()), 32'd2);
      chk("t3_byte0", 32'(wq[0]), 32'h01);
      chk("t3_byte1", 32'(wq[1]), 32'h33);
      chk("t3_wen_req0", 32'(wen_by[0]), 32'd1);
      chk("t3_wen_req3", 32'(wen_by[3]), 32'd1);

      // Ready held low for 500 cycles: nothing may be written
      clear_pkts();
      hold_low = 1'b1;
      arm(0, 1, 32'h00000044, 4'b0001);
      drive();
      repeat (500) tick();
      chk("t4_nowen", 32'(wq.size()), 32'd0);
      chk("t4_noack", 32'(ack_cnt), 32'd0);
      chk("t4_grant", 32'(o_grant), 32'h1);
      hold_low = 1'b0;
      tick();
      chk("t4_wen", 32'(o_tx_wen), 32'h1);
      chk("t4_data", 32'(o_tx_data), 32'h44);
      chk("t4_ack", 32'(o_ack), 32'h1);
      wait_idle("t4_timeout", 5000);

      // Reset in the middle of a packet while waiting on UartTx
      clear_pkts();
      arm(2, 2, 32'h00005251, 4'b0010);
      drive();
      begin
         int n;
         n = 0;
         while (!o_tx_wen && n < 10) begin
            tick();
            n++;
         end
         chk("t5_first_wen", 32'(o_tx_wen), 32'h1);
      end
      repeat (10) tick();
      chk("t5_busy_wait", 32'(o_busy), 32'h1);
      chk("t5_grant_wait", 32'(o_grant), 32'h4);
      i_rst = 1'b1;
      tick();
      chk("t5_rst_grant", 32'(o_grant), 32'h0);
      chk("t5_rst_ack", 32'(o_ack), 32'h0);
      chk("t5_rst_wen", 32'(o_tx_wen), 32'h0);
      chk("t5_rst_busy", 32'(o_busy), 32'h0);
      chk("t5_rst_data", 32'(o_tx_data), 32'h0);
      i_rst = 1'b0;
      clear_pkts();
      arm(1, 1, 32'h00000061, 4'b0001);
      drive();
      tick();
      chk("t5_grant_c1", 32'(o_grant), 32'h2);
      tick();
      chk("t5_wen_c2", 32'(o_tx_wen), 32'h1);
      chk("t5_data_c2", 32'(o_tx_data), 32'h61);
      chk("t5_ack_c2", 32'(o_ack), 32'h2);
      wait_idle("t5_timeout", 5000);
`endif
      chk("grant_onehot", 32'(multi_hot), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
